// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side signals of the two-way instruction cache.
// The cache connects through the slave modport; fetch and memory model use master.
interface icache_2way_if;
    logic        cpu_stall;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_stop;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  cpu_stall, cpu_req, cpu_addr,
        output cpu_stop, cpu_rsp_valid, cpu_rsp_data,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output cpu_stall, cpu_req, cpu_addr,
        input  cpu_stop, cpu_rsp_valid, cpu_rsp_data,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative read-only instruction cache with LRU replacement and line refill FSM.
// Define ICACHE_PERF_EN to add the saturating perf_hits / perf_misses counter outputs.
module icache_2way #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inv,
    icache_2way_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses
`endif
);
    localparam int WB  = $clog2(LINE_WORDS);
    localparam int OFS = WB + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - IDX - OFS;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t state;
    state_t state_next;

    logic [31:0]    data_mem [2][SETS*LINE_WORDS];
    logic [TAG-1:0] tag_mem  [2][SETS];
    logic [SETS-1:0] valid0;
    logic [SETS-1:0] valid1;
    logic [SETS-1:0] lru;

    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] req_idx;
    logic [31:0]    req_addr;
    logic           victim;
    logic           drop;
    logic [WB-1:0]  cnt;
    logic           rsp_valid;
    logic [31:0]    rsp_data;

    logic [TAG-1:0] look_tag;
    logic [IDX-1:0] look_idx;
    logic [WB-1:0]  look_word;
    logic           lookup;
    logic           hit0;
    logic           hit1;
    logic           hit;
    logic           miss;
    logic           victim_sel;
    logic [31:0]    hit_data;
    logic           beat;
    logic           last_beat;
    logic           unused_addr_bits;

    assign look_tag  = bus.cpu_addr[31:OFS+IDX];
    assign look_idx  = bus.cpu_addr[OFS+IDX-1:OFS];
    assign look_word = bus.cpu_addr[OFS-1:2];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign lookup = (state == IDLE) && bus.cpu_req && !bus.cpu_stall;
    assign hit0   = valid0[look_idx] && (tag_mem[0][look_idx] == look_tag);
    assign hit1   = valid1[look_idx] && (tag_mem[1][look_idx] == look_tag);
    assign hit    = lookup && (hit0 || hit1);
    assign miss   = lookup && !(hit0 || hit1);

    assign hit_data = hit1 ? data_mem[1][{look_idx, look_word}]
                           : data_mem[0][{look_idx, look_word}];

    // An invalid way is always preferred over evicting a live line.
    assign victim_sel = !valid0[look_idx] ? 1'b0 :
                        !valid1[look_idx] ? 1'b1 : lru[look_idx];

    assign beat      = (state == FILL) && bus.mem_rsp_valid;
    assign last_beat = beat && (cnt == WB'(LINE_WORDS - 1));

    assign bus.cpu_stop      = miss || (state != IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = req_addr;
    assign bus.cpu_rsp_valid = rsp_valid;
    assign bus.cpu_rsp_data  = rsp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = REQ;
            REQ:     if (bus.mem_req_ready) state_next = FILL;
            FILL:    if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state; inv is applied last so it wins over a same-cycle valid set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid0    <= '0;
            valid1    <= '0;
            lru       <= '0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_addr  <= '0;
            victim    <= 1'b0;
            drop      <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= hit;
            if (hit) begin
                rsp_data      <= hit_data;
                lru[look_idx] <= ~hit1;
            end
            if (miss) begin
                req_tag  <= look_tag;
                req_idx  <= look_idx;
                req_addr <= {look_tag, look_idx, {OFS{1'b0}}};
                victim   <= victim_sel;
                drop     <= 1'b0;
            end
            if (inv && (state != IDLE)) begin
                drop <= 1'b1;
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
            end
            if (last_beat) begin
                lru[req_idx] <= ~victim;
                if (!drop) begin
                    if (victim) valid1[req_idx] <= 1'b1;
                    else        valid0[req_idx] <= 1'b1;
                end
            end
            if (inv) begin
                valid0 <= '0;
                valid1 <= '0;
            end
        end
    end

    // Line storage has no reset; valid bits alone decide whether contents are used.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_mem[victim][{req_idx, cnt}] <= bus.mem_rsp_data;
        end
        if (last_beat) begin
            tag_mem[victim][req_idx] <= req_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (hit && (perf_hits != 32'hFFFF_FFFF)) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (miss && (perf_misses != 32'hFFFF_FFFF)) begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!reset) !(lookup && hit0 && hit1));

endmodule
